axi4_lite_calib_bank: RTL and testbench

- Parametrised AXI4-Lite register bank holding per-channel gain and offset factors for CH_NUM ADC channels.
- Software writes a shadow set of factors, then requests a commit.
- The whole set is copied atomically to the active outputs on the next frame strobe (i_sync), or immediately in IMMEDIATE mode.
- Sits between the PS AXI interconnect and the ADC scaling datapath, so coefficients never change mid-frame.

---
 rtl/calib_bank_pkg.sv | 28 ++
 rtl/calib_commit_fsm.sv | 82 ++++++++
 rtl/axi4_lite_calib_bank.sv | 226 ++++++++++++++++++++++
 tb/tb_axi4_lite_calib_bank.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/calib_bank_pkg.sv
// calib_bank_pkg
// Shared definitions for the AXI4-Lite calibration register bank:
// register word indices, CTRL bit positions, AXI response codes and
// the commit FSM state type.
package calib_bank_pkg;

    // Word indices (byte address >> 2)
    localparam int unsigned IDX_CTRL    = 0;
    localparam int unsigned IDX_STATUS  = 1;
    localparam int unsigned IDX_INFO    = 2;
    localparam int unsigned IDX_CH_BASE = 4;  // gain c at 4+2c, offset c at 5+2c

    // CTRL bit positions
    localparam int unsigned CTRL_COMMIT    = 0;
    localparam int unsigned CTRL_IMMEDIATE = 1;
    localparam int unsigned CTRL_ABORT     = 2;
    localparam int unsigned CTRL_RB_ACTIVE = 3;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        ST_IDLE,
        ST_ARMED
    } commit_state_t;

endpackage

// File: rtl/calib_commit_fsm.sv
// calib_commit_fsm
// Decides when the shadow factor set is copied to the active set.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_sync          frame strobe (commit point while armed)
//   ctrl_wr         accepted CTRL write with byte lane 0 enabled
//   ctrl_commit     COMMIT bit of that write
//   ctrl_immediate  IMMEDIATE bit of that write (new CTRL value)
//   ctrl_abort      ABORT bit of that write
//   armed           FSM is waiting for i_sync
//   xfer            active <= shadow on this clock edge
//   commit_cnt      number of completed transfers (wraps)
//   o_update        one-cycle pulse in the cycle after a transfer
module calib_commit_fsm
    import calib_bank_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_sync,
    input  logic        ctrl_wr,
    input  logic        ctrl_commit,
    input  logic        ctrl_immediate,
    input  logic        ctrl_abort,
    output logic        armed,
    output logic        xfer,
    output logic [15:0] commit_cnt,
    output logic        o_update
);

    commit_state_t state, state_nxt;
    logic          imm_pend;
    logic          arm_req;
    logic          imm_req;
    logic          abort_req;

    // ABORT dominates COMMIT within the same write
    assign abort_req = ctrl_wr && ctrl_abort;
    assign arm_req   = ctrl_wr && ctrl_commit && !ctrl_abort && !ctrl_immediate;
    assign imm_req   = ctrl_wr && ctrl_commit && !ctrl_abort && ctrl_immediate
                       && (state == ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            imm_pend   <= 1'b0;
            commit_cnt <= '0;
            o_update   <= 1'b0;
        end else begin
            state    <= state_nxt;
            // Immediate transfer is deferred one cycle after the CTRL write
            imm_pend <= imm_req;
            o_update <= xfer;
            if (xfer) begin
                commit_cnt <= commit_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                // An i_sync coinciding with the arming write is not consumed
                if (arm_req) begin
                    state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (abort_req || i_sync) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        armed = (state == ST_ARMED);
        xfer  = ((state == ST_ARMED) && i_sync && !abort_req) || imm_pend;
    end

endmodule

// File: rtl/axi4_lite_calib_bank.sv
// axi4_lite_calib_bank
// AXI4-Lite register bank of per-channel gain/offset factors. Software
// writes the shadow set and requests a commit; the whole set is copied
// to the active outputs on the next i_sync (or at once in IMMEDIATE mode).
// Ports:
//   S_AXI_ACLK, S_AXI_ARESET  clock, asynchronous active-high reset
//   i_sync                    one-cycle frame strobe (commit point)
//   o_gain, o_offset          active factors, channel 0 in the LSBs
//   o_update                  pulse in the cycle after the active set loads
//   S_AXI_*                   AXI4-Lite slave (PROT ignored)
module axi4_lite_calib_bank
    import calib_bank_pkg::*;
#(
    parameter int unsigned CH_NUM             = 8,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 8,
    parameter logic [C_S_AXI_DATA_WIDTH-1:0] GAIN_RST   = 32'h3F80_0000,
    parameter logic [C_S_AXI_DATA_WIDTH-1:0] OFFSET_RST = 32'h0000_0000
) (
    input  logic                                 S_AXI_ACLK,
    input  logic                                 S_AXI_ARESET,
    input  logic                                 i_sync,
    output logic [CH_NUM*C_S_AXI_DATA_WIDTH-1:0] o_gain,
    output logic [CH_NUM*C_S_AXI_DATA_WIDTH-1:0] o_offset,
    output logic                                 o_update,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
    input  logic [2:0]                           S_AXI_AWPROT,
    input  logic                                 S_AXI_AWVALID,
    output logic                                 S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
    input  logic                                 S_AXI_WVALID,
    output logic                                 S_AXI_WREADY,
    output logic [1:0]                           S_AXI_BRESP,
    output logic                                 S_AXI_BVALID,
    input  logic                                 S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
    input  logic [2:0]                           S_AXI_ARPROT,
    input  logic                                 S_AXI_ARVALID,
    output logic                                 S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
    output logic [1:0]                           S_AXI_RRESP,
    output logic                                 S_AXI_RVALID,
    input  logic                                 S_AXI_RREADY
);

    localparam int unsigned DW   = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW   = DW / 8;
    localparam int unsigned NREG = IDX_CH_BASE + 2 * CH_NUM;

    logic [DW-1:0] sh_gain    [CH_NUM];
    logic [DW-1:0] sh_offset  [CH_NUM];
    logic [DW-1:0] act_gain   [CH_NUM];
    logic [DW-1:0] act_offset [CH_NUM];

    logic          axi_awready, axi_wready, axi_bvalid;
    logic          axi_arready, axi_rvalid;
    logic [1:0]    axi_bresp, axi_rresp;
    logic [DW-1:0] axi_rdata;

    logic          ctrl_imm, rb_active;
    logic          wr_hs, ctrl_wr;
    int unsigned   w_idx, r_idx;
    logic [DW-1:0] rd_data;
    logic [1:0]    rd_resp;

    logic          armed, xfer;
    logic [15:0]   commit_cnt;

    logic          unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                             S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign w_idx = 32'(S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2]);
    assign r_idx = 32'(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]);

    // READY pulses one cycle after both VALIDs, so the handshake cycle is
    // the cycle where the registered READYs are high.
    assign wr_hs   = axi_awready && S_AXI_AWVALID && axi_wready && S_AXI_WVALID;
    assign ctrl_wr = wr_hs && (w_idx == IDX_CTRL) && S_AXI_WSTRB[0];

    // ---------------- write channel ----------------
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            axi_awready <= 1'b0;
            axi_wready  <= 1'b0;
            axi_bvalid  <= 1'b0;
            axi_bresp   <= RESP_OKAY;
        end else begin
            if (!axi_awready && S_AXI_AWVALID && S_AXI_WVALID && !axi_bvalid) begin
                axi_awready <= 1'b1;
                axi_wready  <= 1'b1;
            end else begin
                axi_awready <= 1'b0;
                axi_wready  <= 1'b0;
            end
            if (wr_hs) begin
                axi_bvalid <= 1'b1;
                axi_bresp  <= (w_idx < NREG) ? RESP_OKAY : RESP_SLVERR;
            end else if (axi_bvalid && S_AXI_BREADY) begin
                axi_bvalid <= 1'b0;
            end
        end
    end

    // CTRL: only IMMEDIATE and RB_ACTIVE are stored; COMMIT/ABORT are strobes
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            ctrl_imm  <= 1'b0;
            rb_active <= 1'b0;
        end else if (ctrl_wr) begin
            ctrl_imm  <= S_AXI_WDATA[CTRL_IMMEDIATE];
            rb_active <= S_AXI_WDATA[CTRL_RB_ACTIVE];
        end
    end

    // Shadow set, byte lanes gated by WSTRB
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            for (int unsigned c = 0; c < CH_NUM; c++) begin
                sh_gain[c]   <= GAIN_RST;
                sh_offset[c] <= OFFSET_RST;
            end
        end else if (wr_hs) begin
            for (int unsigned c = 0; c < CH_NUM; c++) begin
                for (int unsigned b = 0; b < SW; b++) begin
                    if (S_AXI_WSTRB[b] && (w_idx == IDX_CH_BASE + 2 * c)) begin
                        sh_gain[c][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                    end
                    if (S_AXI_WSTRB[b] && (w_idx == IDX_CH_BASE + 2 * c + 1)) begin
                        sh_offset[c][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                    end
                end
            end
        end
    end

    // Active set: a shadow write on the transfer edge is not seen here,
    // so the pre-write shadow value is what gets copied.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            for (int unsigned c = 0; c < CH_NUM; c++) begin
                act_gain[c]   <= GAIN_RST;
                act_offset[c] <= OFFSET_RST;
            end
        end else if (xfer) begin
            for (int unsigned c = 0; c < CH_NUM; c++) begin
                act_gain[c]   <= sh_gain[c];
                act_offset[c] <= sh_offset[c];
            end
        end
    end

    // ---------------- read channel ----------------
    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        if (r_idx >= NREG) begin
            rd_resp = RESP_SLVERR;
        end else if (r_idx == IDX_CTRL) begin
            rd_data[CTRL_IMMEDIATE] = ctrl_imm;
            rd_data[CTRL_RB_ACTIVE] = rb_active;
        end else if (r_idx == IDX_STATUS) begin
            rd_data[0]     = armed;
            rd_data[31:16] = commit_cnt;
        end else if (r_idx == IDX_INFO) begin
            rd_data = DW'(CH_NUM);
        end
        for (int unsigned c = 0; c < CH_NUM; c++) begin
            if (r_idx == IDX_CH_BASE + 2 * c) begin
                rd_data = rb_active ? act_gain[c] : sh_gain[c];
            end
            if (r_idx == IDX_CH_BASE + 2 * c + 1) begin
                rd_data = rb_active ? act_offset[c] : sh_offset[c];
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            axi_arready <= 1'b0;
            axi_rvalid  <= 1'b0;
            axi_rdata   <= '0;
            axi_rresp   <= RESP_OKAY;
        end else begin
            axi_arready <= !axi_arready && S_AXI_ARVALID && !axi_rvalid;
            if (axi_arready && S_AXI_ARVALID) begin
                axi_rvalid <= 1'b1;
                axi_rdata  <= rd_data;
                axi_rresp  <= rd_resp;
            end else if (axi_rvalid && S_AXI_RREADY) begin
                axi_rvalid <= 1'b0;
            end
        end
    end

    // ---------------- commit control ----------------
    calib_commit_fsm u_commit_fsm (
        .clk            (S_AXI_ACLK),
        .rst            (S_AXI_ARESET),
        .i_sync         (i_sync),
        .ctrl_wr        (ctrl_wr),
        .ctrl_commit    (S_AXI_WDATA[CTRL_COMMIT]),
        .ctrl_immediate (S_AXI_WDATA[CTRL_IMMEDIATE]),
        .ctrl_abort     (S_AXI_WDATA[CTRL_ABORT]),
        .armed          (armed),
        .xfer           (xfer),
        .commit_cnt     (commit_cnt),
        .o_update       (o_update)
    );

    for (genvar c = 0; c < CH_NUM; c++) begin : g_out
        assign o_gain[c*DW +: DW]   = act_gain[c];
        assign o_offset[c*DW +: DW] = act_offset[c];
    end

    assign S_AXI_AWREADY = axi_awready;
    assign S_AXI_WREADY  = axi_wready;
    assign S_AXI_BRESP   = axi_bresp;
    assign S_AXI_BVALID  = axi_bvalid;
    assign S_AXI_ARREADY = axi_arready;
    assign S_AXI_RDATA   = axi_rdata;
    assign S_AXI_RRESP   = axi_rresp;
    assign S_AXI_RVALID  = axi_rvalid;

endmodule

// File: tb/tb_axi4_lite_calib_bank.sv
// tb_axi4_lite_calib_bank
// Directed bench for axi4_lite_calib_bank with hand-computed expectations.
module tb_axi4_lite_calib_bank;

    localparam int unsigned CH = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            i_sync = 1'b0;
    logic [CH*32-1:0] o_gain, o_offset;
    logic            o_update;
    logic [7:0]      awaddr = '0, araddr = '0;
    logic            awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
    logic            arvalid = 1'b0, rready = 1'b0;
    logic [31:0]     wdata = '0;
    logic [3:0]      wstrb = '0;
    logic            awready, wready, bvalid, arready, rvalid;
    logic [1:0]      bresp, rresp;
    logic [31:0]     rdata;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    axi4_lite_calib_bank #(
        .CH_NUM             (CH),
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (8)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (rst),
        .i_sync        (i_sync),
        .o_gain        (o_gain),
        .o_offset      (o_offset),
        .o_update      (o_update),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (3'b000),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (3'b000),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // sync_at_hs drives i_sync high during the write handshake cycle
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input bit sync_at_hs,
                             output logic [1:0] resp);
        int n;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!awready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("aw_ready_wait", 32'(awready), 32'd1);
        if (sync_at_hs) i_sync = 1'b1;
        @(posedge clk); #1;
        i_sync = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        n = 0;
        while (!bvalid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("b_valid_wait", 32'(bvalid), 32'd1);
        resp = bresp;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int n;
        araddr = addr; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("ar_ready_wait", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        n = 0;
        while (!rvalid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("r_valid_wait", 32'(rvalid), 32'd1);
        data = rdata; resp = rresp;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic sync_pulse();
        i_sync = 1'b1;
        @(posedge clk); #1;
        i_sync = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_update", 32'(o_update), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < CH; c++) begin
            check("rst_gain", o_gain[c*32 +: 32], 32'h3F80_0000);
            check("rst_offset", o_offset[c*32 +: 32], 32'h0);
        end
        axi_read(8'h10, d, r); check("rd_gain0", d, 32'h3F80_0000); check("rd_gain0_resp", 32'(r), 32'd0);
        axi_read(8'h14, d, r); check("rd_off0", d, 32'h0);
        axi_read(8'h08, d, r); check("rd_info", d, 32'd8);
        axi_read(8'h04, d, r); check("rd_status_rst", d, 32'h0);

        // ---- synchronous commit ----
        axi_write(8'h28, 32'h4000_0000, 4'hF, 1'b0, r); check("wr_gain3_resp", 32'(r), 32'd0);
        axi_write(8'h00, 32'h1, 4'h1, 1'b0, r);
        axi_read(8'h04, d, r); check("status_armed", d, 32'h0000_0001);
        repeat (10) @(posedge clk);
        #1;
        check("gain3_before_sync", o_gain[3*32 +: 32], 32'h3F80_0000);
        check("no_update_before_sync", 32'(o_update), 32'd0);
        sync_pulse();
        check("update_pulse", 32'(o_update), 32'd1);
        check("gain3_after_sync", o_gain[3*32 +: 32], 32'h4000_0000);
        @(posedge clk); #1;
        check("update_single", 32'(o_update), 32'd0);
        axi_read(8'h04, d, r); check("status_cnt1", d, 32'h0001_0000);

        // ---- partial strobe, active readback ----
        axi_write(8'h10, 32'h0000_AB00, 4'b0010, 1'b0, r);
        axi_read(8'h10, d, r); check("rd_gain0_strb", d, 32'h3F80_AB00);
        axi_write(8'h00, 32'h8, 4'h1, 1'b0, r);
        axi_read(8'h00, d, r); check("rd_ctrl_rb", d, 32'h8);
        axi_read(8'h10, d, r); check("rd_gain0_active", d, 32'h3F80_0000);
        axi_read(8'h28, d, r); check("rd_gain3_active", d, 32'h4000_0000);
        axi_write(8'h00, 32'h0, 4'h1, 1'b0, r);

        // ---- out of range ----
        axi_write(8'h50, 32'hDEAD_BEEF, 4'hF, 1'b0, r); check("oor_bresp", 32'(r), 32'd2);
        axi_read(8'h50, d, r);
        check("oor_rdata", d, 32'h0);
        check("oor_rresp", 32'(r), 32'd2);
        axi_read(8'h4C, d, r); check("last_off_unchanged", d, 32'h0);
        axi_read(8'h10, d, r); check("gain0_unchanged", d, 32'h3F80_AB00);

        // ---- commit with coincident i_sync, then abort ----
        axi_write(8'h00, 32'h1, 4'h1, 1'b1, r);
        check("sync_at_arm_no_update", 32'(o_update), 32'd0);
        axi_read(8'h04, d, r); check("armed_after_coincident", d, 32'h0001_0001);
        axi_write(8'h00, 32'h4, 4'h1, 1'b0, r);
        axi_read(8'h04, d, r); check("abort_clears", d, 32'h0001_0000);
        sync_pulse();
        check("abort_no_update", 32'(o_update), 32'd0);
        check("abort_no_xfer", o_gain[31:0], 32'h3F80_0000);
        axi_write(8'h00, 32'h5, 4'h1, 1'b0, r);
        axi_read(8'h04, d, r); check("commit_abort_same", d, 32'h0001_0000);

        // ---- immediate commit ----
        axi_write(8'h4C, 32'hBF00_0000, 4'hF, 1'b0, r);
        check("off7_not_yet", o_offset[7*32 +: 32], 32'h0);
        axi_write(8'h00, 32'h3, 4'h1, 1'b0, r);
        check("imm_update", 32'(o_update), 32'd1);
        check("imm_off7", o_offset[7*32 +: 32], 32'hBF00_0000);
        check("imm_gain0", o_gain[31:0], 32'h3F80_AB00);
        axi_read(8'h04, d, r); check("imm_status", d, 32'h0002_0000);

        // ---- reset while armed ----
        axi_write(8'h00, 32'h1, 4'h1, 1'b0, r);
        axi_read(8'h04, d, r); check("armed_again", d, 32'h0002_0001);
        #2 rst = 1'b1;
        #1;
        check("arst_gain3", o_gain[3*32 +: 32], 32'h3F80_0000);
        check("arst_gain0", o_gain[31:0], 32'h3F80_0000);
        check("arst_off7", o_offset[7*32 +: 32], 32'h0);
        check("arst_update", 32'(o_update), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        axi_read(8'h04, d, r); check("status_after_rst", d, 32'h0);
        axi_read(8'h4C, d, r); check("shadow_off7_rst", d, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
